// File: rtl/gmsk_rx_if.sv
// Sample-side and decision-side signals of the GMSK demodulator, bundled so the
// receive path (master) and the demodulator (slave) share one port.
interface gmsk_rx_if #(
  parameter int BITS_PER_SAMPLE    = 8,
  parameter int SAMPLES_PER_SYMBOL = 8,
  parameter int ACC_WIDTH          = 2*BITS_PER_SAMPLE+1+$clog2(SAMPLES_PER_SYMBOL)
);
  logic                               sample_valid;
  logic signed [BITS_PER_SAMPLE-1:0]  inphase_in;
  logic signed [BITS_PER_SAMPLE-1:0]  quadrature_in;
  logic                               symbol_align;
  logic                               bit_out;
  logic                               bit_strobe;
  logic signed [ACC_WIDTH-1:0]        metric_out;

  modport master (
    output sample_valid, inphase_in, quadrature_in, symbol_align,
    input  bit_out, bit_strobe, metric_out
  );

  modport slave (
    input  sample_valid, inphase_in, quadrature_in, symbol_align,
    output bit_out, bit_strobe, metric_out
  );
endinterface

// File: rtl/gmsk_rx.sv
// GMSK demodulator: one-sample-delay differential phase discriminator integrated per symbol.
// Optional GSM differential decoding of the decisions when GMSK_RX_DIFF_DECODE_EN is defined.
module gmsk_rx #(
  parameter int BITS_PER_SAMPLE    = 8,
  parameter int SAMPLES_PER_SYMBOL = 8,
  parameter int ACC_WIDTH          = 2*BITS_PER_SAMPLE+1+$clog2(SAMPLES_PER_SYMBOL)
) (
  input  logic       clock,
  input  logic       reset_n,
  gmsk_rx_if.slave   bus
);
  localparam int BPS   = BITS_PER_SAMPLE;
  localparam int PW    = 2*BITS_PER_SAMPLE;
  localparam int CNT_W = $clog2(SAMPLES_PER_SYMBOL);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES_PER_SYMBOL-1);

  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           count_eff;
  logic signed [BPS-1:0]      prev_i;
  logic signed [BPS-1:0]      prev_q;
  logic signed [PW-1:0]       ext_prev_i;
  logic signed [PW-1:0]       ext_prev_q;
  logic signed [PW-1:0]       ext_cur_i;
  logic signed [PW-1:0]       ext_cur_q;
  logic signed [PW-1:0]       prod_a;
  logic signed [PW-1:0]       prod_b;
  logic                       s1_valid;
  logic                       s1_first;
  logic                       s1_last;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] disc;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] metric_q;
  logic                       raw;
  logic                       decided;
  logic                       bit_q;
  logic                       strobe_q;
`ifdef GMSK_RX_DIFF_DECODE_EN
  logic                       last_raw;
`endif

  // Operands widened before multiplying so -128*-128 lands as +16384 rather than wrapping
  always_comb begin
    ext_prev_i = {{BPS{prev_i[BPS-1]}}, prev_i};
    ext_prev_q = {{BPS{prev_q[BPS-1]}}, prev_q};
    ext_cur_i  = {{BPS{bus.inphase_in[BPS-1]}}, bus.inphase_in};
    ext_cur_q  = {{BPS{bus.quadrature_in[BPS-1]}}, bus.quadrature_in};
    count_eff  = bus.symbol_align ? '0 : count;
  end

  always_comb begin
    disc = {{(ACC_WIDTH-PW){prod_a[PW-1]}}, prod_a} - {{(ACC_WIDTH-PW){prod_b[PW-1]}}, prod_b};
    sum  = (s1_first ? '0 : acc) + disc;
    raw  = !sum[ACC_WIDTH-1] && (sum != '0);
`ifdef GMSK_RX_DIFF_DECODE_EN
    decided = raw ^ last_raw;
`else
    decided = raw;
`endif
  end

  // Stage 0: products against the previous sample and symbol-phase tracking
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_i   <= '0;
      prev_q   <= '0;
      prod_a   <= '0;
      prod_b   <= '0;
      count    <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= bus.sample_valid;
      if (bus.sample_valid) begin
        prod_a   <= ext_prev_i * ext_cur_q;
        prod_b   <= ext_prev_q * ext_cur_i;
        s1_first <= (count_eff == '0);
        s1_last  <= (count_eff == LAST_IDX);
        prev_i   <= bus.inphase_in;
        prev_q   <= bus.quadrature_in;
        count    <= (count_eff == LAST_IDX) ? '0 : count_eff + CNT_W'(1);
      end else if (bus.symbol_align) begin
        count    <= '0;
      end
    end
  end

  // Stage 1: integrate and decide; an align pulse discards whatever stage 1 holds
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      metric_q <= '0;
      bit_q    <= 1'b0;
      strobe_q <= 1'b0;
`ifdef GMSK_RX_DIFF_DECODE_EN
      last_raw <= 1'b0;
`endif
    end else begin
      strobe_q <= 1'b0;
      if (bus.symbol_align) begin
        acc      <= '0;
`ifdef GMSK_RX_DIFF_DECODE_EN
        last_raw <= 1'b0;
`endif
      end else if (s1_valid) begin
        if (s1_last) begin
          metric_q <= sum;
          bit_q    <= decided;
          strobe_q <= 1'b1;
          acc      <= '0;
`ifdef GMSK_RX_DIFF_DECODE_EN
          last_raw <= raw;
`endif
        end else begin
          acc      <= sum;
        end
      end
    end
  end

  assign bus.bit_out    = bit_q;
  assign bus.bit_strobe = strobe_q;
  assign bus.metric_out = metric_q;

endmodule

// File: tb/tb_gmsk_rx.sv
// Randomised self-checking bench for gmsk_rx against a per-symbol sum-of-discriminators model.
module tb_gmsk_rx;
  localparam int BPS = 8;
  localparam int SPS = 8;
  localparam int AW  = 2*BPS+1+$clog2(SPS);

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  gmsk_rx_if #(.BITS_PER_SAMPLE(BPS), .SAMPLES_PER_SYMBOL(SPS), .ACC_WIDTH(AW)) bus ();

  gmsk_rx #(.BITS_PER_SAMPLE(BPS), .SAMPLES_PER_SYMBOL(SPS), .ACC_WIDTH(AW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model: symbol metric is the plain sum of prev_i*q - prev_q*i over the symbol's samples
  longint m_prev_i, m_prev_q;
  longint m_discs[$];
  bit     m_pend;
  longint m_pend_metric;
  bit     m_last_raw;

  bit     exp_strobe, exp_bit;
  longint exp_metric;
  logic   obs_strobe, obs_bit;
  logic signed [AW-1:0] obs_metric;
  logic signed [AW-1:0] exp_metric_w;

  int pos_i[4] = '{100, 0, -100, 0};
  int pos_q[4] = '{0, 100, 0, -100};
  int neg_i[4] = '{100, 0, -100, 0};
  int neg_q[4] = '{0, -100, 0, 100};

  task automatic model_reset();
    m_prev_i = 0; m_prev_q = 0;
    m_discs.delete();
    m_pend = 0; m_pend_metric = 0; m_last_raw = 0;
    exp_strobe = 0; exp_bit = 0; exp_metric = 0;
  endtask

  // Drives one clock of stimulus from a negedge and samples outputs at the next negedge
  task automatic step(input bit v, input int i, input int q, input bit align);
    bit raw;
    longint s;
    bus.sample_valid  = v;
    bus.inphase_in    = BPS'(i);
    bus.quadrature_in = BPS'(q);
    bus.symbol_align  = align;
    exp_strobe = m_pend && !align;
    m_pend = 0;
    if (exp_strobe) begin
      exp_metric = m_pend_metric;
      raw = (m_pend_metric > 0);
`ifdef GMSK_RX_DIFF_DECODE_EN
      exp_bit = raw ^ m_last_raw;
`else
      exp_bit = raw;
`endif
      m_last_raw = raw;
    end
    if (align) begin
      m_discs.delete();
      m_last_raw = 0;
    end
    if (v) begin
      m_discs.push_back(m_prev_i*longint'(q) - m_prev_q*longint'(i));
      m_prev_i = i; m_prev_q = q;
      if (m_discs.size() == SPS) begin
        s = 0;
        foreach (m_discs[k]) s += m_discs[k];
        m_pend = 1; m_pend_metric = s;
        m_discs.delete();
      end
    end
    @(posedge clock);
    @(negedge clock);
    obs_strobe = bus.bit_strobe;
    obs_bit    = bus.bit_out;
    obs_metric = bus.metric_out;
    exp_metric_w = AW'(exp_metric);
    bus.sample_valid = 1'b0;
    bus.symbol_align = 1'b0;
  endtask

  task automatic test_reset();
    bus.sample_valid = 1'b0; bus.symbol_align = 1'b0;
    bus.inphase_in = '0; bus.quadrature_in = '0;
    #2 reset_n = 1'b0;
    #1;
    n_compared++;
    if ({bus.bit_strobe, bus.bit_out, bus.metric_out} !== {1'b0, 1'b0, {AW{1'b0}}}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: got strobe=%0b bit=%0b metric=%0d, want all 0",
               bus.bit_strobe, bus.bit_out, $signed(bus.metric_out));
    end
    model_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    step(0, 0, 0, 0);
    n_compared++;
    if ({obs_strobe, obs_bit, obs_metric} !== {1'b0, 1'b0, {AW{1'b0}}}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_release: got strobe=%0b bit=%0b metric=%0d, want all 0",
               obs_strobe, obs_bit, obs_metric);
    end
  endtask

  task automatic test_rotation();
    longint want_metric[4] = '{70000, 80000, -60000, -80000};
    int sym = 0;
    for (int n = 0; n < 4*SPS + 1; n++) begin
      if (n < 2*SPS)      step(1, pos_i[n%4], pos_q[n%4], 0);
      else if (n < 4*SPS) step(1, neg_i[n%4], neg_q[n%4], 0);
      else                step(0, 0, 0, 0);
      n_compared++;
      if ({obs_strobe, obs_bit, obs_metric} !== {exp_strobe, exp_bit, exp_metric_w}) begin
        n_mismatched++;
        $display("[TB] FAIL rotation step %0d: got strobe=%0b bit=%0b metric=%0d, want strobe=%0b bit=%0b metric=%0d",
                 n, obs_strobe, obs_bit, obs_metric, exp_strobe, exp_bit, exp_metric_w);
      end
      if (obs_strobe === 1'b1 && sym < 4) begin
        n_compared++;
        if (obs_metric !== AW'(want_metric[sym])) begin
          n_mismatched++;
          $display("[TB] FAIL rotation_metric sym %0d: got %0d, want %0d", sym, obs_metric, want_metric[sym]);
        end
        sym++;
      end
    end
    n_compared++;
    if (sym != 4) begin
      n_mismatched++;
      $display("[TB] FAIL rotation_strobe_count: got %0d, want 4", sym);
    end
  endtask

  task automatic test_constant_gaps();
    int strobes = 0;
    step(1, 50, 50, 0);
    step(0, 0, 0, 1);
    for (int n = 0; n < 2*SPS + 2; n++) begin
      if (n < 2*SPS) begin
        repeat ($urandom_range(0, 3)) begin
          step(0, 0, 0, 0);
          n_compared++;
          if ({obs_strobe, obs_bit, obs_metric} !== {exp_strobe, exp_bit, exp_metric_w}) begin
            n_mismatched++;
            $display("[TB] FAIL constant_gap: got strobe=%0b bit=%0b metric=%0d, want strobe=%0b bit=%0b metric=%0d",
                     obs_strobe, obs_bit, obs_metric, exp_strobe, exp_bit, exp_metric_w);
          end
          if (obs_strobe === 1'b1) strobes++;
        end
        step(1, 50, 50, 0);
      end else begin
        step(0, 0, 0, 0);
      end
      n_compared++;
      if ({obs_strobe, obs_bit, obs_metric} !== {exp_strobe, exp_bit, exp_metric_w}) begin
        n_mismatched++;
        $display("[TB] FAIL constant step %0d: got strobe=%0b bit=%0b metric=%0d, want strobe=%0b bit=%0b metric=%0d",
                 n, obs_strobe, obs_bit, obs_metric, exp_strobe, exp_bit, exp_metric_w);
      end
      if (obs_strobe === 1'b1) begin
        strobes++;
        n_compared++;
        if ({obs_bit, obs_metric} !== {1'b0, {AW{1'b0}}}) begin
          n_mismatched++;
          $display("[TB] FAIL constant_zero: got bit=%0b metric=%0d, want 0/0", obs_bit, obs_metric);
        end
      end
    end
    n_compared++;
    if (strobes != 2) begin
      n_mismatched++;
      $display("[TB] FAIL constant_strobe_count: got %0d, want 2", strobes);
    end
  endtask

  task automatic test_extreme();
    int vi, vq;
    for (int n = 0; n < 6*SPS + 2; n++) begin
      if (n < 2*SPS) begin
        vi = (n % 2 == 0) ? -128 : 127;
        vq = -128;
        step(1, vi, vq, 0);
      end else if (n < 6*SPS) begin
        vi = ($urandom_range(0, 1) == 1) ? 127 : -128;
        vq = ($urandom_range(0, 1) == 1) ? 127 : -128;
        step(1, vi, vq, 0);
      end else begin
        step(0, 0, 0, 0);
      end
      n_compared++;
      if ({obs_strobe, obs_bit, obs_metric} !== {exp_strobe, exp_bit, exp_metric_w}) begin
        n_mismatched++;
        $display("[TB] FAIL extreme step %0d: got strobe=%0b bit=%0b metric=%0d, want strobe=%0b bit=%0b metric=%0d",
                 n, obs_strobe, obs_bit, obs_metric, exp_strobe, exp_bit, exp_metric_w);
      end
    end
  endtask

  task automatic test_align();
    int strobes = 0;
    step(0, 0, 0, 1);
    for (int n = 0; n < 5 + 1 + 7 + 2; n++) begin
      if (n < 5)       step(1, pos_i[n%4], pos_q[n%4], 0);
      else if (n == 5) step(1, pos_i[n%4], pos_q[n%4], 1);
      else if (n < 13) step(1, pos_i[n%4], pos_q[n%4], 0);
      else             step(0, 0, 0, 0);
      n_compared++;
      if ({obs_strobe, obs_bit, obs_metric} !== {exp_strobe, exp_bit, exp_metric_w}) begin
        n_mismatched++;
        $display("[TB] FAIL align step %0d: got strobe=%0b bit=%0b metric=%0d, want strobe=%0b bit=%0b metric=%0d",
                 n, obs_strobe, obs_bit, obs_metric, exp_strobe, exp_bit, exp_metric_w);
      end
      if (obs_strobe === 1'b1) strobes++;
    end
    n_compared++;
    if (strobes != 1) begin
      n_mismatched++;
      $display("[TB] FAIL align_strobe_count: got %0d, want 1", strobes);
    end
    // Last sample of a symbol in stage 1 when align arrives: its decision must vanish
    for (int n = 0; n < SPS; n++) step(1, neg_i[n%4], neg_q[n%4], 0);
    step(0, 0, 0, 1);
    n_compared++;
    if (obs_strobe !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL align_suppress: got strobe=%0b, want 0", obs_strobe);
    end
  endtask

  task automatic test_async_reset();
    for (int n = 0; n < SPS + 1; n++) step(n < SPS, pos_i[n%4], pos_q[n%4], 0);
    for (int n = 0; n < 3; n++) step(1, pos_i[n%4], pos_q[n%4], 0);
    #2 reset_n = 1'b0;
    #1;
    n_compared++;
    if ({bus.bit_strobe, bus.bit_out, bus.metric_out} !== {1'b0, 1'b0, {AW{1'b0}}}) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset: got strobe=%0b bit=%0b metric=%0d, want all 0",
               bus.bit_strobe, bus.bit_out, $signed(bus.metric_out));
    end
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    for (int n = 0; n < SPS + 2; n++) begin
      if (n < SPS) step(1, pos_i[n%4], pos_q[n%4], 0);
      else         step(0, 0, 0, 0);
      n_compared++;
      if ({obs_strobe, obs_bit, obs_metric} !== {exp_strobe, exp_bit, exp_metric_w}) begin
        n_mismatched++;
        $display("[TB] FAIL post_reset step %0d: got strobe=%0b bit=%0b metric=%0d, want strobe=%0b bit=%0b metric=%0d",
                 n, obs_strobe, obs_bit, obs_metric, exp_strobe, exp_bit, exp_metric_w);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit v, al;
    for (int n = 0; n < 300; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      al = ($urandom_range(0, 39) == 0);
      step(v, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, al);
      n_compared++;
      if ({obs_strobe, obs_bit, obs_metric} !== {exp_strobe, exp_bit, exp_metric_w}) begin
        n_mismatched++;
        $display("[TB] FAIL random step %0d: got strobe=%0b bit=%0b metric=%0d, want strobe=%0b bit=%0b metric=%0d",
                 n, obs_strobe, obs_bit, obs_metric, exp_strobe, exp_bit, exp_metric_w);
      end
    end
  endtask

`ifdef GMSK_RX_DIFF_DECODE_EN
  task automatic test_diff_decode();
    bit want_bits[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int sym = 0;
    #2 reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    for (int n = 0; n < 5*SPS + 1; n++) begin
      if (n < 2*SPS)      step(1, pos_i[n%4], pos_q[n%4], 0);
      else if (n < 4*SPS) step(1, neg_i[n%4], neg_q[n%4], 0);
      else if (n < 5*SPS) step(1, pos_i[n%4], pos_q[n%4], 0);
      else                step(0, 0, 0, 0);
      if (obs_strobe === 1'b1 && sym < 5) begin
        n_compared++;
        if (obs_bit !== want_bits[sym]) begin
          n_mismatched++;
          $display("[TB] FAIL diff_decode sym %0d: got bit=%0b, want %0b", sym, obs_bit, want_bits[sym]);
        end
        sym++;
      end
    end
    n_compared++;
    if (sym != 5) begin
      n_mismatched++;
      $display("[TB] FAIL diff_strobe_count: got %0d, want 5", sym);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_constant_gaps();
    test_extreme();
    test_align();
    test_async_reset();
    test_back_to_back();
`ifdef GMSK_RX_DIFF_DECODE_EN
    test_diff_decode();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
